// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the round-robin comparator arbiter: output-stage state and result flags.
package cmp_arbiter_pkg;

  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

endpackage

// File: rtl/cmp4_core.sv
// Purely combinational unsigned magnitude comparator; the first differing bit from the MSB decides.
module cmp4_core #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!gt && !lt && (a[i] != b[i])) begin
        gt = a[i];
        lt = b[i];
      end
    end
    eq = !gt && !lt;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared comparator into a single-entry registered output stage.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       rsp_eq,
  output logic                       rsp_gt,
  output logic                       rsp_lt
);

  localparam int unsigned IdW = $clog2(N_REQ);

  out_state_e         state_q;
  logic [IdW-1:0]     ptr_q;
  logic [IdW-1:0]     id_q;
  cmp_flags_t         flags_q;

  logic [N_REQ-1:0]   gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               slot_free;
  logic               transfer;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;
  cmp_flags_t         cmp_res;

  // Requesters at or above start win first; if none, wrap to the lowest valid index.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IdW-1:0]   start);
    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] pick;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = valid[i] && (i >= int'(start));
    end
    if (upper == '0) upper = valid;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (upper[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

  assign slot_free = (state_q == StEmpty) || rsp_ready;
  assign gnt       = rr_pick(req_valid, ptr_q);
  assign req_ready = (slot_free && !rst) ? gnt : '0;
  assign transfer  = |req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = IdW'(i);
    end
  end

  assign sel_a = req_a[gnt_idx*W +: W];
  assign sel_b = req_b[gnt_idx*W +: W];

  cmp4_core #(
    .W (W)
  ) u_cmp (
    .a  (sel_a),
    .b  (sel_b),
    .eq (cmp_res.eq),
    .gt (cmp_res.gt),
    .lt (cmp_res.lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      id_q    <= '0;
      flags_q <= '0;
    end else if (transfer) begin
      // Covers both the EMPTY load and the FULL drain-and-reload in one cycle.
      state_q <= StFull;
      id_q    <= gnt_idx;
      flags_q <= cmp_res;
      ptr_q   <= (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
    end else if ((state_q == StFull) && rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_id    = id_q;
  assign rsp_eq    = flags_q.eq;
  assign rsp_gt    = flags_q.gt;
  assign rsp_lt    = flags_q.lt;

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the comparator; legal range 2..8.
REQ-002 Parameter: W, default 4, operand width in bits; fixed at 4 for this release.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: req_valid  input  N_REQ  per-requester operand pair valid.
REQ-006 Port: req_a  input  N_REQ*W  packed operand A; requester i uses bits [i*W +: W].
REQ-007 Port: req_b  input  N_REQ*W  packed operand B; same packing as req_a.
REQ-008 Port: req_ready  output  N_REQ  one-hot grant; requester i's transfer occurs when req_valid[i] & req_ready[i].
REQ-009 Port: rsp_valid  output  1  a result is held in the output register.
REQ-010 Port: rsp_ready  input  1  downstream accepts the result.
REQ-011 Port: rsp_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-012 Port: rsp_eq, rsp_gt, rsp_lt  output  1 each  unsigned comparison flags for A against B; exactly one is high whenever rsp_valid is high.

Function
REQ-013 The block SHALL share one comparator instance among all requesters, accepting at most one request per cycle.
REQ-014 Output stage states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 A slot is free in a cycle when the state is EMPTY, or when the state is FULL and rsp_ready=1.
REQ-016 req_ready SHALL be combinational and zero unless a slot is free and at least one req_valid bit is set.
REQ-017 When a slot is free, the block SHALL assert req_ready for exactly one valid requester, chosen by round-robin.
REQ-018 Round-robin order: search from pointer ptr upward, wrapping from N_REQ-1 to 0; the first requester with req_valid set wins.
REQ-019 On a transfer to requester g, ptr SHALL become (g+1) mod N_REQ; otherwise ptr SHALL hold.
REQ-020 Latency: the comparison result and rsp_id SHALL be registered on the transfer edge and presented with rsp_valid=1 in the following cycle (1-cycle latency).
REQ-021 Throughput: a simultaneous drain and new grant (state FULL, rsp_ready=1, request pending) SHALL load the new result with no bubble, sustaining 1 result per cycle.
REQ-022 Hold: while the state is FULL and rsp_ready=0, rsp_id and the rsp_* flags SHALL stay stable and req_ready SHALL be all-zero.
REQ-023 Drain without a new request: FULL with rsp_ready=1 and no req_valid SHALL move to EMPTY.
REQ-024 Comparison semantics: eq = (A==B); gt = A>B; lt = A<B; unsigned, decided MSB-first.
REQ-025 Requesters may drop req_valid without a transfer; the arbiter SHALL hold no per-requester state other than ptr.
REQ-026 In state EMPTY, the rsp_* flags and rsp_id are don't-care; the bench SHALL NOT check them.

Reset
REQ-027 While rst=1 at a clock edge: rsp_valid=0, rsp_id=0, rsp_eq=0, rsp_gt=0, rsp_lt=0, ptr=0, state EMPTY.
REQ-028 While rst=1, req_ready SHALL be forced to all-zero.
REQ-029 Reset asserted mid-operation SHALL discard any held result with no response emitted; after release, arbitration restarts at requester 0.

Structure
REQ-030 A shared package SHALL hold the output-state enum (EMPTY/FULL) and the result-flag struct {eq, gt, lt}.
REQ-031 The comparator SHALL be a separate purely combinational sub-module, cmp4_core (ports a, b, eq, gt, lt), instantiated exactly once.
REQ-032 The round-robin select SHALL be written as a function inside cmp_arbiter, not as a separate module.

Verification
REQ-033 Reset, then requester 2 presents A=9, B=3 -> req_ready=0100; the next cycle shows rsp_valid=1, rsp_id=2, gt=1.
REQ-034 All four requesters are valid continuously and rsp_ready=1 -> grants follow 0,1,2,3,0 on consecutive cycles with one result per cycle.
REQ-035 rsp_ready is held at 0 for 3 cycles while the state is FULL with requests pending -> req_ready=0000 and rsp_* is stable; on release, the drain and the next grant occur in the same cycle.
REQ-036 Boundary operands A=B=15, A=0/B=15, A=15/B=0 -> eq, lt, gt respectively, one-hot.
REQ-037 rst is asserted while FULL with ptr=3 -> next cycle rsp_valid=0; the first grant after release goes to requester 0 when all requesters are valid.
REQ-038 Random valid/ready traffic with a scoreboard -> every transfer is answered once, in order, with correct flags, and no requester waits more than N_REQ grants.
